// File: rtl/fft_frame_sched_pkg.sv
// Shared constants for the FFT frame scheduler: sample format, FFT size and FSM encodings.
// Optional feature macro used by the scheduler: FFT_SCHED_PRIO_EN.
package fft_frame_sched_pkg;

   localparam int DATA_WID     = 16;
   localparam int FFT_LEN      = 64;
   localparam int LOG2_FFT_LEN = 6;

   localparam logic [1:0] FFT_SCHED_ST_IDLE   = 2'd0;
   localparam logic [1:0] FFT_SCHED_ST_STREAM = 2'd1;
   localparam logic [1:0] FFT_SCHED_ST_GAP    = 2'd2;

   // Width of a source ID for a given source count; never narrower than one bit.
   function automatic int fft_sched_ch_wid(input int n_ch);
      return (n_ch <= 2) ? 1 : $clog2(n_ch);
   endfunction

endpackage

// File: rtl/fft_frame_sched_if.sv
// Source-side bundle of the FFT frame scheduler: per-source frame requests, sample buses and grants.
interface fft_frame_sched_if #(
   parameter int N_CH = 4,
   parameter int DW   = 16
);
   // req_i[c] means source c holds a complete frame; while gnt_o[c] is high the scheduler consumes
   // the sample on slice c every cycle and the source must present the next one the following cycle.
   logic [N_CH-1:0]    req_i;
   logic [N_CH*DW-1:0] src_re_i;
   logic [N_CH*DW-1:0] src_im_i;
   logic [N_CH-1:0]    gnt_o;

   modport master (output req_i, output src_re_i, output src_im_i, input gnt_o);
   modport slave  (input req_i, input src_re_i, input src_im_i, output gnt_o);
endinterface

// File: rtl/fft_tag_fifo.sv
// Synchronous FIFO holding source IDs of frames in flight; push and pop may coincide when full.
module fft_tag_fifo #(
   parameter int WID   = 2,
   parameter int DEPTH = 4,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           push_i,
   input  logic [WID-1:0] data_i,
   input  logic           pop_i,
   output logic [WID-1:0] head_o,
   output logic           full_o,
   output logic           empty_o,
   output logic [AW:0]    count_o
);

   logic [WID-1:0] mem_q [DEPTH];
   logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]    cnt_q, cnt_d;
   logic           do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign count_o = cnt_q;
   assign head_o  = mem_q[rd_q];

   // A push into a full FIFO is accepted only when the head leaves in the same cycle.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = (wr_q == AW'(DEPTH-1)) ? '0 : wr_q + AW'(1);
      if (do_pop)  rd_d = (rd_q == AW'(DEPTH-1)) ? '0 : rd_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/fft_frame_sched.sv
// Round-robin scheduler feeding one shared FFT core with whole frames and tagging its output frames.
// Define FFT_SCHED_PRIO_EN to give source 0 strict priority over the round-robin sources.
module fft_frame_sched
   import fft_frame_sched_pkg::*;
#(
   parameter int N_CH      = 4,
   parameter int TAG_DEPTH = 4,
   parameter int GAP_CYC   = 1,
   localparam int CH_WID   = fft_sched_ch_wid(N_CH)
) (
   input  logic                clk,
   input  logic                rst_n,
   fft_frame_sched_if.slave    src_if,
   output logic                fft_val_o,
   output logic [DATA_WID-1:0] fft_re_o,
   output logic [DATA_WID-1:0] fft_im_o,
   input  logic                fft_val_i,
   output logic [CH_WID-1:0]   out_ch_o,
   output logic                out_sof_o,
   output logic                out_eof_o,
   output logic                busy_o,
   output logic                err_o,
   output logic [1:0]          dbg_state_o
);

   localparam int CW     = LOG2_FFT_LEN;
   localparam int GW     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int TAG_AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

   logic [1:0]          state_q, state_d;
   logic [CH_WID-1:0]   ptr_q, ptr_d, win_q, win_d;
   logic [N_CH-1:0]     gnt_q, gnt_d;
   logic [CW-1:0]       cnt_q, cnt_d, ocnt_q, ocnt_d;
   logic [GW-1:0]       gap_q, gap_d;
   logic                val_q, val_d, err_q, err_d;
   logic [DATA_WID-1:0] re_q, re_d, im_q, im_d;

   logic [N_CH-1:0]     rr_req;
   logic                rr_found, prio_hit, any_req;
   logic [CH_WID-1:0]   rr_idx, win_idx;
   logic                push, pop;
   logic [CH_WID-1:0]   fifo_head;
   logic                fifo_full, fifo_empty;
   logic [TAG_AW:0]     fifo_cnt;

`ifdef FFT_SCHED_PRIO_EN
   assign prio_hit = src_if.req_i[0];
   assign rr_req   = {src_if.req_i[N_CH-1:1], 1'b0};
`else
   assign prio_hit = 1'b0;
   assign rr_req   = src_if.req_i;
`endif

   assign any_req = |src_if.req_i;
   assign win_idx = prio_hit ? '0 : rr_idx;

   // Search starts just after the last round-robin winner and wraps.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int i = 1; i <= N_CH; i++) begin
         if (!rr_found && rr_req[(int'(ptr_q) + i) % N_CH]) begin
            rr_found = 1'b1;
            rr_idx   = CH_WID'((int'(ptr_q) + i) % N_CH);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      val_d   = 1'b0;
      re_d    = '0;
      im_d    = '0;
      push    = 1'b0;
      case (state_q)
         FFT_SCHED_ST_IDLE: begin
            if (any_req && !fifo_full) begin
               push    = 1'b1;
               win_d   = win_idx;
               gnt_d   = N_CH'(1) << win_idx;
               cnt_d   = '0;
               state_d = FFT_SCHED_ST_STREAM;
               if (!prio_hit) ptr_d = win_idx;
            end
         end
         FFT_SCHED_ST_STREAM: begin
            val_d = 1'b1;
            re_d  = src_if.src_re_i[int'(win_q)*DATA_WID +: DATA_WID];
            im_d  = src_if.src_im_i[int'(win_q)*DATA_WID +: DATA_WID];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(FFT_LEN-1)) begin
               gnt_d   = '0;
               cnt_d   = '0;
               gap_d   = '0;
               state_d = FFT_SCHED_ST_GAP;
            end
         end
         FFT_SCHED_ST_GAP: begin
            // Idle input cycles let the FFT core's sample counter return to zero.
            if (gap_q == GW'(GAP_CYC-1)) state_d = FFT_SCHED_ST_IDLE;
            else                          gap_d   = gap_q + GW'(1);
         end
         default: begin
            gnt_d   = '0;
            state_d = FFT_SCHED_ST_IDLE;
         end
      endcase
   end

   assign out_sof_o = fft_val_i & (ocnt_q == '0);
   assign out_eof_o = fft_val_i & (ocnt_q == CW'(FFT_LEN-1));
   assign pop       = out_eof_o & ~fifo_empty;
   assign ocnt_d    = fft_val_i ? ocnt_q + CW'(1) : ocnt_q;
   assign err_d     = err_q | (fft_val_i & fifo_empty);
   assign out_ch_o  = fifo_empty ? '0 : fifo_head;

   fft_tag_fifo #(
      .WID   (CH_WID),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  (win_d),
      .pop_i   (pop),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FFT_SCHED_ST_IDLE;
         ptr_q   <= CH_WID'(N_CH-1);
         win_q   <= '0;
         gnt_q   <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
         val_q   <= 1'b0;
         re_q    <= '0;
         im_q    <= '0;
         ocnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         val_q   <= val_d;
         re_q    <= re_d;
         im_q    <= im_d;
         ocnt_q  <= ocnt_d;
         err_q   <= err_d;
      end
   end

   assign src_if.gnt_o = gnt_q;
   assign fft_val_o    = val_q;
   assign fft_re_o     = re_q;
   assign fft_im_o     = im_q;
   assign err_o        = err_q;
   assign busy_o       = (state_q != FFT_SCHED_ST_IDLE) | (fifo_cnt != '0);
   assign dbg_state_o  = state_q;

endmodule
